vga_sync_monitor: RTL

Receive-side counterpart to the VGA timing generator. Samples the `h_sync`/`v_sync`/RGB stream on the pixel clock and recovers active-pixel coordinates and data-enable. Checks line and frame timing against 640x480 parameters and tracks lock. Exposes one pixel-probe capture for on-board self-test and verification of the display path.

---
 rtl/vga_sync_monitor.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: receive-side VGA timing recovery. Registers the incoming
// sync/RGB stream, rebuilds the line/frame position, checks every line and
// frame against the nominal timing, tracks lock and offers one probe pixel.
module vga_sync_monitor #(
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic        de,
    output logic [9:0]  x_loc,
    output logic [9:0]  y_loc,
    output logic [11:0] pix,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic [7:0]  err_cnt,
    output logic [15:0] frame_cnt,
    output logic [11:0] probe_rgb,
    output logic        probe_valid
);

    localparam logic [1:0] S_SEARCH  = 2'd0;
    localparam logic [1:0] S_ACQUIRE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    localparam logic [9:0]  CNT_MAX = 10'h3FF;
    localparam logic [9:0]  HA_LO   = 10'(H_SYNC + H_BP);
    localparam logic [9:0]  HA_HI   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0]  VA_LO   = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  VA_HI   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_LOW   = 10'(H_SYNC);
    localparam logic [9:0]  V_LOW   = 10'(V_SYNC);
    localparam logic [10:0] TO_LIM  = 11'(2 * H_TOTAL);
    localparam logic [10:0] TO_MAX  = 11'h7FF;

    // Input sample stage: current and previous sample of each sync line.
    // Syncs idle high so a stream that begins low still yields an edge.
    logic        hs_q, hs_p, vs_q, vs_p;
    logic [11:0] rgb_q;

    // Position and timing-check state
    logic [9:0]  hc, vc;          // position of the previous sample
    logic [9:0]  hlow_cnt;        // h_sync low run length of current pulse
    logic [9:0]  hlow_lat;        // width of the last completed pulse
    logic [9:0]  vlow_cnt;        // h edges seen with v_sync low this frame
    logic [10:0] to_cnt;          // cycles since the last h edge
    logic        hq, vq;          // line / frame checks qualified
    logic        vpend;           // v edge seen, waiting for its h edge
    logic        clean;
    logic [1:0]  state, state_n;
    logic        clean_n;

    // Decode of the registered sample
    logic        h_edge, h_rise, v_edge, frame_start, timeout;
    logic [9:0]  hc_cur, vc_cur;
    logic [10:0] to_cur;
    logic        h_bad, v_bad, h_err_n, v_err_n, any_err;
    logic        de_n, hit;
    logic [9:0]  x_n, y_n;

    function automatic logic [9:0] inc_sat(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

    // Register the raw inputs once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_q  <= 1'b1;
            hs_p  <= 1'b1;
            vs_q  <= 1'b1;
            vs_p  <= 1'b1;
            rgb_q <= '0;
        end else begin
            hs_q  <= h_sync;
            hs_p  <= hs_q;
            vs_q  <= v_sync;
            vs_p  <= vs_q;
            rgb_q <= {red, green, blue};
        end
    end

    assign h_edge      = hs_p & ~hs_q;
    assign h_rise      = ~hs_p & hs_q;
    assign v_edge      = vs_p & ~vs_q;
    // A v edge counts from the first h edge at or after it, same cycle included
    assign frame_start = h_edge & (vpend | v_edge);

    assign hc_cur  = h_edge ? 10'd0 : inc_sat(hc);
    assign vc_cur  = frame_start ? 10'd0 : (h_edge ? inc_sat(vc) : vc);
    assign to_cur  = h_edge ? 11'd0 : ((to_cnt == TO_MAX) ? to_cnt : to_cnt + 11'd1);
    assign timeout = (to_cur == TO_LIM);

    // Checks compare against the previous line/frame, so they need one
    // full period of history before they mean anything.
    assign h_bad   = h_edge & hq & ((hc != H_LAST) | (hlow_lat != H_LOW));
    assign v_bad   = frame_start & vq & ((vc != V_LAST) | (vlow_cnt != V_LOW));
    assign h_err_n = h_bad & (state != S_SEARCH);
    assign v_err_n = v_bad & (state != S_SEARCH);
    assign any_err = h_err_n | v_err_n;

    // Lock FSM: two consecutive error-free frame starts in ACQUIRE to lock
    always_comb begin
        state_n = state;
        clean_n = clean;
        if (timeout) begin
            state_n = S_SEARCH;
            clean_n = 1'b0;
        end else begin
            case (state)
                S_SEARCH: begin
                    if (frame_start) begin
                        state_n = S_ACQUIRE;
                        clean_n = 1'b0;
                    end
                end
                S_ACQUIRE: begin
                    if (any_err)
                        clean_n = 1'b0;
                    else if (frame_start) begin
                        if (clean) state_n = S_LOCKED;
                        else       clean_n = 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (any_err) begin
                        state_n = S_ACQUIRE;
                        clean_n = 1'b0;
                    end
                end
                default: begin
                    state_n = S_SEARCH;
                    clean_n = 1'b0;
                end
            endcase
        end
    end

    // Active-region decode; de follows the next state so it drops together
    // with locked on the cycle an error is reported.
    always_comb begin
        de_n = (hc_cur >= HA_LO) && (hc_cur <= HA_HI) &&
               (vc_cur >= VA_LO) && (vc_cur <= VA_HI) &&
               (state_n == S_LOCKED);
        x_n  = de_n ? (hc_cur - HA_LO) : 10'd0;
        y_n  = de_n ? (vc_cur - VA_LO) : 10'd0;
        hit  = de_n && (x_n == probe_x) && (y_n == probe_y);
    end

    // Line/frame position, pulse widths and qualification flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hc       <= '0;
            vc       <= '0;
            hlow_cnt <= '0;
            hlow_lat <= '0;
            vlow_cnt <= '0;
            to_cnt   <= '0;
            hq       <= 1'b0;
            vq       <= 1'b0;
            vpend    <= 1'b0;
        end else begin
            hc     <= hc_cur;
            vc     <= vc_cur;
            to_cnt <= to_cur;

            if (!hs_q)
                hlow_cnt <= h_edge ? 10'd1 : inc_sat(hlow_cnt);
            if (h_rise)
                hlow_lat <= hlow_cnt;

            if (frame_start)
                vlow_cnt <= vs_q ? 10'd0 : 10'd1;
            else if (h_edge && !vs_q)
                vlow_cnt <= inc_sat(vlow_cnt);

            if (timeout) begin
                hq    <= 1'b0;
                vq    <= 1'b0;
                vpend <= 1'b0;
            end else begin
                if (h_edge)      hq <= 1'b1;
                if (frame_start) vq <= 1'b1;
                if (frame_start) vpend <= 1'b0;
                else if (v_edge) vpend <= 1'b1;
            end
        end
    end

    // Lock state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_SEARCH;
            clean <= 1'b0;
        end else begin
            state <= state_n;
            clean <= clean_n;
        end
    end

    assign locked = (state == S_LOCKED);

    // Registered video outputs, error reporting, counters and probe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de          <= 1'b0;
            x_loc       <= '0;
            y_loc       <= '0;
            pix         <= '0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
            err_cnt     <= '0;
            frame_cnt   <= '0;
            probe_rgb   <= '0;
            probe_valid <= 1'b0;
        end else begin
            de          <= de_n;
            x_loc       <= x_n;
            y_loc       <= y_n;
            pix         <= de_n ? rgb_q : 12'd0;
            h_err       <= h_err_n;
            v_err       <= v_err_n;
            if (any_err && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
            if (frame_start && (state == S_LOCKED))
                frame_cnt <= frame_cnt + 16'd1;
            probe_valid <= hit;
            if (hit)
                probe_rgb <= rgb_q;
        end
    end

endmodule
